flash8_wb_bridge: RTL and testbench

FLASH8_WB_BRIDGE -- requirements
Module: flash8_wb_bridge

---
 rtl/flash8_pkg.sv | 14 +
 rtl/flash8_byte_rd.sv | 69 ++++++
 rtl/flash8_wb_bridge.sv | 103 ++++++++++
 tb/tb_flash8_wb_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/flash8_pkg.sv
// Shared types and defaults for the 8-bit flash to 16-bit Wishbone bridge.
package flash8_pkg;

  localparam int unsigned WaitCyclesDefault = 4;
  localparam int unsigned CntWidth          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StAck
  } state_e;

endpackage

// File: rtl/flash8_byte_rd.sv
// One flash byte read: holds oe_n low for WaitCycles clocks after start, then captures
// the byte into the selected lane of the read-data register and pulses done.
module flash8_byte_rd
  import flash8_pkg::*;
#(
  parameter int unsigned WaitCycles = WaitCyclesDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        clr_i,
  input  logic        lane_i,
  input  logic [7:0]  flash_data_i,
  output logic        oe_n_o,
  output logic        done_o,
  output logic [15:0] dat_o
);

  localparam logic [CntWidth-1:0] Reload = CntWidth'(WaitCycles - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [15:0]         dat_q, dat_d;

  assign done_o = busy_q && (cnt_q == '0) && !abort_i;
  assign oe_n_o = !busy_q;
  assign dat_o  = dat_q;

  // A start coinciding with done (low byte -> high byte) keeps oe_n low and reloads.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = Reload;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    dat_d = dat_q;
    if (clr_i) begin
      dat_d = '0;
    end else if (done_o) begin
      if (lane_i) dat_d[15:8] = flash_data_i;
      else        dat_d[7:0]  = flash_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dat_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/flash8_wb_bridge.sv
// Wishbone 16-bit slave reading an 8-bit parallel flash through a 64 KB window,
// with a 6-bit page register in I/O space selecting the window.
module flash8_wb_bridge
  import flash8_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [16:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_tga_i,
  output logic        wb_ack_o,
  output logic [21:0] flash_addr_,
  input  logic [7:0]  flash_data_,
  output logic        flash_oe_n_,
  output logic        flash_we_n_
);

  state_e      state_q, state_d;
  logic [5:0]  page_q;
  logic        io_rd_q;
  logic        accept, mem_rd, in_rd;
  logic        rd_start, rd_abort, rd_clr, rd_lane, rd_done;
  logic [15:0] rd_dat;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[16], wb_dat_i[15:6]};
  assign flash_we_n_ = 1'b1;

  assign accept   = (state_q == StIdle) && wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign mem_rd   = !wb_tga_i && !wb_we_i;
  assign in_rd    = (state_q == StRdLo) || (state_q == StRdHi);
  assign rd_abort = in_rd && !wb_cyc_i;
  assign rd_clr   = accept && mem_rd;
  assign rd_lane  = (state_q == StRdHi);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!mem_rd)          state_d = StAck;
          else if (wb_sel_i[0]) state_d = StRdLo;
          else                  state_d = StRdHi;
        end
      end
      StRdLo: begin
        if (!wb_cyc_i)    state_d = StIdle;
        else if (rd_done) state_d = wb_sel_i[1] ? StRdHi : StAck;
      end
      StRdHi: begin
        if (!wb_cyc_i)    state_d = StIdle;
        else if (rd_done) state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rd_start = (state_d != state_q) && ((state_d == StRdLo) || (state_d == StRdHi));
  end

  always_comb begin
    wb_ack_o    = (state_q == StAck);
    flash_addr_ = in_rd ? {page_q, wb_adr_i[15:1], rd_lane} : '0;
    wb_dat_o    = io_rd_q ? {10'b0, page_q} : rd_dat;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      page_q  <= '0;
      io_rd_q <= 1'b0;
    end else if (accept) begin
      io_rd_q <= wb_tga_i && !wb_we_i;
      if (wb_tga_i && wb_we_i && wb_sel_i[0]) page_q <= wb_dat_i[5:0];
    end
  end

  flash8_byte_rd #(
    .WaitCycles (WAIT_CYCLES)
  ) u_byte_rd (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .start_i      (rd_start),
    .abort_i      (rd_abort),
    .clr_i        (rd_clr),
    .lane_i       (rd_lane),
    .flash_data_i (flash_data_),
    .oe_n_o       (flash_oe_n_),
    .done_o       (rd_done),
    .dat_o        (rd_dat)
  );

endmodule

// File: tb/tb_flash8_wb_bridge.sv
// Directed bench for flash8_wb_bridge: Wishbone transfers against a simple flash model.
module tb_flash8_wb_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [16:1] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_tga_i = 1'b0;
  logic        wb_ack_o;
  logic [21:0] flash_addr_;
  logic [7:0]  flash_data_;
  logic        flash_oe_n_;
  logic        flash_we_n_;

  int n_total = 0;
  int n_bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  // Two fixed bytes at 0x20/0x21, every other location reads addr[7:0] ^ 8'h5A.
  assign flash_data_ = (flash_addr_ == 22'h000020) ? 8'h34 :
                       (flash_addr_ == 22'h000021) ? 8'h12 : (flash_addr_[7:0] ^ 8'h5A);

  flash8_wb_bridge #(
    .WAIT_CYCLES (4)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_stb_i    (wb_stb_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_tga_i    (wb_tga_i),
    .wb_ack_o    (wb_ack_o),
    .flash_addr_ (flash_addr_),
    .flash_data_ (flash_data_),
    .flash_oe_n_ (flash_oe_n_),
    .flash_we_n_ (flash_we_n_)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the next posedge is the accepting edge. Returns ack latency in
  // edges after acceptance, clocks with oe_n low, data at ack and last flash address seen.
  task automatic wb_xfer(input logic tga, input logic we, input logic [1:0] sel,
                         input logic [15:0] adr, input logic [15:0] dat,
                         output int lat, output int oe_lo, output logic [15:0] rdat,
                         output logic [21:0] last_addr);
    wb_tga_i = tga;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    lat = 0;
    oe_lo = 0;
    rdat = '0;
    last_addr = '0;
    @(posedge wb_clk_i);
    for (int n = 0; n < 40; n++) begin
      @(negedge wb_clk_i);
      if (!flash_oe_n_) begin
        oe_lo++;
        last_addr = flash_addr_;
      end
      if (wb_ack_o) begin
        lat  = n + 1;
        rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    check("ack_single_pulse", {31'b0, wb_ack_o}, 32'd0);
  endtask

  initial begin
    int          lat, oe_lo, acks;
    logic [15:0] rdat;
    logic [21:0] la;

    #12;
    check("rst_oe_n", {31'b0, flash_oe_n_}, 32'd1);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_addr", {10'b0, flash_addr_}, 32'd0);
    check("rst_dat", {16'b0, wb_dat_o}, 32'd0);
    check("we_n_tied", {31'b0, flash_we_n_}, 32'd1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Two-byte read from page 0.
    wb_xfer(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0, lat, oe_lo, rdat, la);
    check("rd2_data", {16'b0, rdat}, 32'h1234);
    check("rd2_lat", lat, 32'd9);
    check("rd2_oe_clocks", oe_lo, 32'd8);
    check("rd2_hi_addr", {10'b0, la}, 32'h000021);

    // Low-byte-only read.
    wb_xfer(1'b0, 1'b0, 2'b01, 16'h0010, 16'h0, lat, oe_lo, rdat, la);
    check("rdlo_data", {16'b0, rdat}, 32'h0034);
    check("rdlo_lat", lat, 32'd5);
    check("rdlo_addr", {10'b0, la}, 32'h000020);

    // Page 3F, top of window, high byte only.
    wb_xfer(1'b1, 1'b1, 2'b11, 16'h0, 16'h003F, lat, oe_lo, rdat, la);
    check("iowr_lat", lat, 32'd1);
    wb_xfer(1'b0, 1'b0, 2'b10, 16'hFFFF, 16'h0, lat, oe_lo, rdat, la);
    check("rdhi_addr", {10'b0, la}, 32'h3FFFFF);
    check("rdhi_lo_zero", {24'b0, rdat[7:0]}, 32'h00);
    check("rdhi_data", {16'b0, rdat}, 32'hA500);
    check("rdhi_lat", lat, 32'd5);
    check("rdhi_oe_clocks", oe_lo, 32'd4);

    // I/O write with only the high lane leaves the page alone.
    wb_xfer(1'b1, 1'b1, 2'b10, 16'h0, 16'h0005, lat, oe_lo, rdat, la);
    check("iowr_hi_lat", lat, 32'd1);
    wb_xfer(1'b1, 1'b0, 2'b11, 16'h0, 16'h0, lat, oe_lo, rdat, la);
    check("iord_page", {16'b0, rdat}, 32'h003F);
    check("iord_lat", lat, 32'd1);

    // Memory write: immediate ack, no flash activity.
    wb_xfer(1'b0, 1'b1, 2'b11, 16'h1234, 16'hBEEF, lat, oe_lo, rdat, la);
    check("memwr_lat", lat, 32'd1);
    check("memwr_oe_clocks", oe_lo, 32'd0);

    // Abort: drop cyc three clocks into RD_LO.
    wb_tga_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 2'b11;
    wb_adr_i = 16'h0010;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge wb_clk_i);
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    check("abort_oe_before", {31'b0, flash_oe_n_}, 32'd0);
    @(negedge wb_clk_i);
    check("abort_oe_high", {31'b0, flash_oe_n_}, 32'd1);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (wb_ack_o) acks++;
      @(negedge wb_clk_i);
    end
    check("abort_no_ack", acks, 32'd0);
    wb_xfer(1'b1, 1'b0, 2'b11, 16'h0, 16'h0, lat, oe_lo, rdat, la);
    check("abort_page_kept", {16'b0, rdat}, 32'h003F);
    wb_xfer(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0, lat, oe_lo, rdat, la);
    check("post_abort_data", {16'b0, rdat}, 32'h7B7A);
    check("post_abort_lat", lat, 32'd9);

    // Reset pulsed while in RD_HI.
    wb_tga_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 2'b11;
    wb_adr_i = 16'h0010;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    @(posedge wb_clk_i);
    repeat (5) @(posedge wb_clk_i);
    #2;
    check("pre_rst_oe_low", {31'b0, flash_oe_n_}, 32'd0);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_oe_n", {31'b0, flash_oe_n_}, 32'd1);
    check("midrst_page", {26'b0, dut.page_q}, 32'd0);
    check("midrst_addr", {10'b0, flash_addr_}, 32'd0);
    check("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wb_xfer(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0, lat, oe_lo, rdat, la);
    check("post_rst_data", {16'b0, rdat}, 32'h1234);
    check("post_rst_lat", lat, 32'd9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
